// File: rtl/w_serial_source_if.sv
// Load/data/pause request and serial W/busy/done status bundle for w_serial_source.
interface w_serial_source_if #(
  parameter int unsigned WIDTH = 8
);
  logic             inputLoad;
  logic [WIDTH-1:0] inputData;
  logic             inputPause;
  logic             outputW;
  logic             outputBusy;
  logic             outputDone;

  // master: sequencer or harness that requests frames
  modport master (
    output inputLoad, inputData, inputPause,
    input  outputW, outputBusy, outputDone
  );

  // slave: the serial source itself
  modport slave (
    input  inputLoad, inputData, inputPause,
    output outputW, outputBusy, outputDone
  );
endinterface

// File: rtl/w_serial_source.sv
// Parallel-to-serial W stimulus source: MSB first, each bit held BIT_CYCLES clocks,
// with pause, busy status and a one-cycle done pulse after the last bit period.
module w_serial_source #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic          inputClk,
  input  logic          inputReset,
  w_serial_source_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PRE_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               w_q, w_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   shifted;

  // State and datapath registers
  always_ff @(posedge inputClk) begin
    if (inputReset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      presc_q  <= '0;
      w_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      presc_q  <= presc_d;
      w_q      <= w_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    presc_d  = presc_q;
    w_d      = w_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    shifted  = shreg_q << 1;

    unique case (state_q)
      IDLE: begin
        w_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.inputLoad) begin
          state_d  = SHIFT;
          shreg_d  = bus.inputData;
          bitcnt_d = '0;
          presc_d  = '0;
          w_d      = bus.inputData[WIDTH-1];
          busy_d   = 1'b1;
        end
      end

      SHIFT: begin
        if (!bus.inputPause) begin
          if (presc_q == PRE_W'(BIT_CYCLES - 1)) begin
            presc_d = '0;
            shreg_d = shifted;
            // Last bit period over: leave with W low and a done pulse
            if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
              state_d  = IDLE;
              bitcnt_d = '0;
              w_d      = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + CNT_W'(1);
              w_d      = shifted[WIDTH-1];
            end
          end else begin
            presc_d = presc_q + PRE_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.outputW    = w_q;
  assign bus.outputBusy = busy_q;
  assign bus.outputDone = done_q;

endmodule
